lcd_8080_ctrl: RTL and testbench

//   APB slave that turns CPU register writes into Intel-8080 style parallel write cycles for the LCD panel.

---
 rtl/lcd_8080_ctrl.sv | 158 +++++++++++++++
 tb/tb_lcd_8080_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_8080_ctrl.sv
// APB slave that queues CPU writes and replays them as Intel-8080 style write cycles
// on the LCD panel bus, with programmable strobe timing and a completed-transfer counter.
module lcd_8080_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int DB_W       = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk_ext8m,
    input  logic             rst,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [4:0]       paddr,
    input  logic [31:0]      pwdata,
    output logic [31:0]      prdata,
    output logic             pready,
    output logic [DB_W-1:0]  LCD_DB,
    output logic             LCD_RS,
    output logic             LCD_WR,
    output logic             LCD_RD,
    output logic             LCD_RST,
    output logic             lcd_pwrite,
    output logic [CNT_W-1:0] lcd_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, LOW, HIGH} state_t;

    logic [DB_W:0]      fifo_q [FIFO_DEPTH];
    logic [AW:0]        wptr_q, rptr_q, fill;
    logic               full, empty, pop, push, push_req, wr_req, flush, busy;
    logic [2:0]         addr, fill3;
    logic [DB_W:0]      head;
    state_t             state_q;
    logic [7:0]         tmr_q, high_q;
    logic [15:0]        timing_q;
    logic               ctrl_rst_q, pwrite_q, wr_q, rs_q;
    logic [DB_W-1:0]    db_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               unused_bits;

    // A programmed duration of 0 behaves as 1; the timer counts down to zero.
    function automatic logic [7:0] cycles_m1(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    assign addr     = paddr[4:2];
    assign wr_req   = psel && penable && pwrite;
    assign push_req = wr_req && (addr == 3'd0 || addr == 3'd1);
    // Flush is never a push, so it cannot be stalled and needs no pready term.
    assign flush    = wr_req && addr == 3'd2 && pwdata[1];
    assign fill     = wptr_q - rptr_q;
    assign full     = fill == FULL_LVL;
    assign empty    = fill == '0;
    assign fill3    = 3'(fill);
    assign head     = fifo_q[rptr_q[AW-1:0]];
    assign pop      = !empty && !flush &&
                      (state_q == IDLE || (state_q == HIGH && tmr_q == 8'd0));
    assign pready   = !(push_req && full && !pop);
    assign push     = push_req && pready;
    assign busy     = state_q != IDLE || !empty;
    assign unused_bits = ^{pwdata, paddr[1:0]};

    always_comb begin
        prdata = '0;
        if (psel && penable && !pwrite) begin
            case (addr)
                3'd2:    prdata = {31'd0, ctrl_rst_q};
                3'd3:    prdata = {16'd0, timing_q};
                3'd4:    prdata = {25'd0, fill3, 1'b0, empty, full, busy};
                3'd5:    prdata = 32'(cnt_q);
                default: prdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_ext8m) begin
        if (push) fifo_q[wptr_q[AW-1:0]] <= {addr[0], pwdata[DB_W-1:0]};
    end

    always_ff @(posedge clk_ext8m or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            timing_q   <= 16'h0202;
            ctrl_rst_q <= 1'b1;
            pwrite_q   <= 1'b0;
        end else begin
            pwrite_q <= wr_req && pready;
            if (flush) begin
                rptr_q <= wptr_q;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
            end
            if (wr_req && addr == 3'd2) ctrl_rst_q <= pwdata[0];
            if (wr_req && addr == 3'd3) timing_q   <= pwdata[15:0];
        end
    end

    // Strobe sequencer: timing is sampled in SETUP so a running transfer keeps its shape.
    always_ff @(posedge clk_ext8m or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            high_q  <= '0;
            db_q    <= '0;
            rs_q    <= 1'b0;
            wr_q    <= 1'b1;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            wr_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    db_q    <= head[DB_W-1:0];
                    rs_q    <= head[DB_W];
                    state_q <= SETUP;
                end
                SETUP: begin
                    wr_q    <= 1'b0;
                    tmr_q   <= cycles_m1(timing_q[7:0]);
                    high_q  <= cycles_m1(timing_q[15:8]);
                    state_q <= LOW;
                end
                LOW: if (tmr_q == 8'd0) begin
                    wr_q    <= 1'b1;
                    cnt_q   <= cnt_q + 1'b1;
                    tmr_q   <= high_q;
                    state_q <= HIGH;
                end else begin
                    tmr_q <= tmr_q - 8'd1;
                end
                HIGH: if (tmr_q != 8'd0) begin
                    tmr_q <= tmr_q - 8'd1;
                end else if (pop) begin
                    db_q    <= head[DB_W-1:0];
                    rs_q    <= head[DB_W];
                    state_q <= SETUP;
                end else begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign LCD_DB     = db_q;
    assign LCD_RS     = rs_q;
    assign LCD_WR     = wr_q;
    assign LCD_RD     = 1'b1;
    assign LCD_RST    = ~ctrl_rst_q;
    assign lcd_pwrite = pwrite_q;
    assign lcd_cnt    = cnt_q;
endmodule

// File: tb/tb_lcd_8080_ctrl.sv
// Directed bench for lcd_8080_ctrl: APB register access, strobe timing, FIFO stall, flush and reset.
module tb_lcd_8080_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [4:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic [15:0] LCD_DB;
    logic        LCD_RS, LCD_WR, LCD_RD, LCD_RST, lcd_pwrite;
    logic [31:0] lcd_cnt;

    int errors = 0;
    int checks = 0;

    lcd_8080_ctrl dut (
        .clk_ext8m(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .LCD_DB(LCD_DB), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD),
        .LCD_RST(LCD_RST), .lcd_pwrite(lcd_pwrite), .lcd_cnt(lcd_cnt)
    );

    always #5 clk = ~clk;

    // Bus monitor: logs every rising LCD_WR with the bus value and its low length.
    logic [16:0] cap_val [64];
    int          cap_low [64];
    int          fall_cyc [64];
    int          ncap = 0, nfall = 0, cyc = 0, low_run = 0, pw_cnt = 0;
    logic        prev_wr = 1'b1;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (lcd_pwrite) pw_cnt <= pw_cnt + 1;
        if (prev_wr && !LCD_WR) begin
            fall_cyc[nfall % 64] <= cyc;
            nfall <= nfall + 1;
        end
        if (!LCD_WR) begin
            low_run <= low_run + 1;
        end else if (!prev_wr) begin
            cap_val[ncap % 64] <= {LCD_RS, LCD_DB};
            cap_low[ncap % 64] <= low_run;
            ncap    <= ncap + 1;
            low_run <= 0;
        end
        prev_wr <= LCD_WR;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output int stalls);
        stalls = 0;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1;
        while (!pready && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        checks++;
        if (!pready) begin
            errors++;
            $display("FAIL apb_write_timeout: pready=%b after %0d cycles, required 1 (addr %h)", pready, stalls, a);
        end
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1;
        d = prdata;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        wait_cyc(2);
        checks++;
        if ({LCD_WR, LCD_RD, LCD_RST, LCD_RS, pready, lcd_pwrite} !== 6'b110010) begin
            errors++;
            $display("FAIL reset_ctl: WR,RD,RST,RS,pready,pwrite=%b required 110010",
                     {LCD_WR, LCD_RD, LCD_RST, LCD_RS, pready, lcd_pwrite});
        end
        checks++;
        if (LCD_DB !== 16'h0 || lcd_cnt !== 32'h0 || prdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: db=%h cnt=%h prdata=%h required all 0", LCD_DB, lcd_cnt, prdata);
        end
        @(negedge clk);
        rst = 1'b0;
        apb_read(5'h0C, rd);
        checks++;
        if (rd !== 32'h0202) begin errors++; $display("FAIL reset_timing: got %h required 00000202", rd); end
        apb_read(5'h10, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL reset_status: got %h required 00000004", rd); end
        apb_read(5'h08, rd);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL reset_ctrl: got %h required 00000001", rd); end
    endtask

    task automatic test_ctrl();
        logic [31:0] rd;
        int st, p0;
        p0 = pw_cnt;
        apb_write(5'h08, 32'h0, st);
        wait_cyc(1);
        checks++;
        if (LCD_RST !== 1'b1) begin errors++; $display("FAIL ctrl_lcd_rst: got %b required 1", LCD_RST); end
        checks++;
        if (pw_cnt - p0 !== 1) begin errors++; $display("FAIL ctrl_pwrite_once: got %0d pulses required 1", pw_cnt - p0); end
        apb_read(5'h08, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_readback: got %h required 00000000", rd); end
        apb_write(5'h0C, 32'h0202, st);
        apb_read(5'h14, rd);
        checks++;
        if (pw_cnt - p0 !== 2) begin errors++; $display("FAIL ctrl_pwrite_count: got %0d pulses required 2", pw_cnt - p0); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL cnt_reg_idle: got %h required 00000000", rd); end
    endtask

    task automatic test_single_cmd();
        logic [31:0] rd;
        int st, base;
        base = ncap;
        apb_write(5'h00, 32'hFFFF002C, st);
        wait_cyc(1);
        checks++;
        if ({LCD_WR, LCD_RS, LCD_DB} !== {1'b1, 1'b0, 16'h002C}) begin
            errors++;
            $display("FAIL cmd_setup: wr=%b rs=%b db=%h required wr=1 rs=0 db=002c", LCD_WR, LCD_RS, LCD_DB);
        end
        wait_cyc(1);
        checks++;
        if (LCD_WR !== 1'b0) begin errors++; $display("FAIL cmd_wr_fall: got %b required 0", LCD_WR); end
        wait_cyc(8);
        checks++;
        if (ncap - base !== 1 || cap_val[base % 64] !== 17'h0002C || cap_low[base % 64] !== 2) begin
            errors++;
            $display("FAIL cmd_capture: n=%0d val=%h low=%0d required n=1 val=0002c low=2",
                     ncap - base, cap_val[base % 64], cap_low[base % 64]);
        end
        checks++;
        if (lcd_cnt !== 32'd1) begin errors++; $display("FAIL cmd_cnt: got %0d required 1", lcd_cnt); end
        apb_read(5'h10, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL cmd_status: got %h required 00000004", rd); end
    endtask

    task automatic test_back_to_back();
        int st, base;
        int stalls [6];
        apb_write(5'h08, 32'h2, st);
        apb_write(5'h0C, 32'h0606, st);
        base = ncap;
        for (int i = 0; i < 6; i++) apb_write(5'h04, 32'hA000 + i, stalls[i]);
        checks++;
        if (stalls[0] + stalls[1] + stalls[2] + stalls[3] + stalls[4] !== 0 || stalls[5] !== 4) begin
            errors++;
            $display("FAIL b2b_stall: stalls=%0d,%0d,%0d,%0d,%0d,%0d required 0,0,0,0,0,4",
                     stalls[0], stalls[1], stalls[2], stalls[3], stalls[4], stalls[5]);
        end
        wait_cyc(100);
        checks++;
        if (ncap - base !== 6) begin errors++; $display("FAIL b2b_count: got %0d transfers required 6", ncap - base); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cap_val[(base + i) % 64] !== {1'b1, 16'hA000 + 16'(i)} || cap_low[(base + i) % 64] !== 6) begin
                errors++;
                $display("FAIL b2b_word%0d: val=%h low=%0d required val=%h low=6", i,
                         cap_val[(base + i) % 64], cap_low[(base + i) % 64], {1'b1, 16'hA000 + 16'(i)});
            end
        end
        checks++;
        if (lcd_cnt !== 32'd6) begin errors++; $display("FAIL b2b_cnt: got %0d required 6", lcd_cnt); end
    endtask

    task automatic test_fast_timing();
        int st, base, fb;
        apb_write(5'h0C, 32'h0, st);
        base = ncap;
        fb = nfall;
        for (int i = 0; i < 3; i++) apb_write(5'h04, 32'hB1 + i, st);
        wait_cyc(10);
        checks++;
        if (ncap - base !== 3 || nfall - fb !== 3) begin
            errors++;
            $display("FAIL fast_count: rises=%0d falls=%0d required 3 and 3", ncap - base, nfall - fb);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap_val[(base + i) % 64] !== {1'b1, 16'h00B1 + 16'(i)} || cap_low[(base + i) % 64] !== 1) begin
                errors++;
                $display("FAIL fast_word%0d: val=%h low=%0d required val=%h low=1", i,
                         cap_val[(base + i) % 64], cap_low[(base + i) % 64], {1'b1, 16'h00B1 + 16'(i)});
            end
        end
        checks++;
        if (fall_cyc[(fb + 1) % 64] - fall_cyc[fb % 64] !== 3 || fall_cyc[(fb + 2) % 64] - fall_cyc[(fb + 1) % 64] !== 3) begin
            errors++;
            $display("FAIL fast_period: %0d and %0d cycles required 3 and 3",
                     fall_cyc[(fb + 1) % 64] - fall_cyc[fb % 64], fall_cyc[(fb + 2) % 64] - fall_cyc[(fb + 1) % 64]);
        end
        checks++;
        if (lcd_cnt !== 32'd9) begin errors++; $display("FAIL fast_cnt: got %0d required 9", lcd_cnt); end
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        int st, base;
        apb_write(5'h0C, 32'h1010, st);
        for (int i = 0; i < 4; i++) apb_write(5'h04, 32'hC0 + i, st);
        apb_read(5'h10, rd);
        checks++;
        if (rd !== 32'h31 || LCD_WR !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre: status=%h wr=%b required status=00000031 wr=0", rd, LCD_WR);
        end
        apb_write(5'h08, 32'h2, st);
        checks++;
        if (LCD_WR !== 1'b1 || lcd_cnt !== 32'd0) begin
            errors++;
            $display("FAIL flush_abort: wr=%b cnt=%0d required wr=1 cnt=0", LCD_WR, lcd_cnt);
        end
        apb_read(5'h10, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL flush_status: got %h required 00000004", rd); end
        base = ncap;
        wait_cyc(40);
        checks++;
        if (ncap - base !== 0 || lcd_cnt !== 32'd0) begin
            errors++;
            $display("FAIL flush_quiet: strobes=%0d cnt=%0d required 0 and 0", ncap - base, lcd_cnt);
        end
    endtask

    task automatic test_rst_mid_low();
        logic [31:0] rd;
        int st, base;
        apb_write(5'h0C, 32'h0, st);
        apb_write(5'h04, 32'hD1, st);
        wait_cyc(6);
        apb_write(5'h0C, 32'h0808, st);
        apb_write(5'h04, 32'hD2, st);
        wait_cyc(2);
        checks++;
        if (LCD_WR !== 1'b0 || lcd_cnt !== 32'd1) begin
            errors++;
            $display("FAIL rst_pre: wr=%b cnt=%0d required wr=0 cnt=1", LCD_WR, lcd_cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({LCD_WR, LCD_RST, LCD_RS} !== 3'b100 || lcd_cnt !== 32'd0 || LCD_DB !== 16'h0) begin
            errors++;
            $display("FAIL rst_async: wr=%b rst=%b rs=%b cnt=%0d db=%h required 1,0,0,0,0000",
                     LCD_WR, LCD_RST, LCD_RS, lcd_cnt, LCD_DB);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(1);
        base = ncap;
        wait_cyc(30);
        checks++;
        if (ncap - base !== 0 || LCD_WR !== 1'b1 || lcd_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_quiet: strobes=%0d wr=%b cnt=%0d required 0,1,0", ncap - base, LCD_WR, lcd_cnt);
        end
        apb_read(5'h10, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL rst_status: got %h required 00000004", rd); end
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_single_cmd();
        test_back_to_back();
        test_fast_timing();
        test_flush();
        test_rst_mid_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
